// File: rtl/odd_pulse_incrementer_pkg.sv
// odd_pulse_pkg: shared constants for the odd-pulse incrementer.
//   CNT_W    - default counter width
//   PAR_EVEN - an even number of pulses seen so far; the next pulse is odd
//   PAR_ODD  - an odd number of pulses seen so far; the next pulse is even
package odd_pulse_pkg;

    localparam int   CNT_W    = 4;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/odd_pulse_incrementer_rise_detect.sv
// rise_detect: registers d once per clock and flags a 0->1 transition.
//   clk  - system clock
//   rst  - asynchronous active-low reset; clears the sampled value
//   d    - level input, synchronous to clk
//   rise - combinational, high while d=1 and the previous sample was 0
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic inc_q;

    // The sample clears to 0, so a level that is already high on the
    // first edge after reset counts as a fresh pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inc_q <= 1'b0;
        else      inc_q <= d;
    end

    assign rise = d & ~inc_q;

endmodule

// File: rtl/odd_pulse_incrementer.sv
// odd_pulse_incrementer: counts the 1st, 3rd, 5th, ... pulse on inc.
// Even-numbered pulses are absorbed, so cnt = ceil(pulses/2) mod 2^WIDTH.
//   clk - system clock
//   rst - asynchronous active-low reset; clears cnt, parity and edge history
//   inc - increment request; a pulse is a 0->1 transition sampled on clk
//   cnt - registered count of odd-numbered pulses; wraps with no saturation
module odd_pulse_incrementer
    import odd_pulse_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    if (WIDTH < 1) begin : g_bad_width
        $error("odd_pulse_incrementer: WIDTH must be at least 1");
    end

    logic rise;
    logic odd_seen;

    rise_detect u_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (inc),
        .rise (rise)
    );

    // Parity of the pulses seen so far; flips on every detected pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      odd_seen <= PAR_EVEN;
        else if (rise) odd_seen <= (odd_seen == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
    end

    // A pulse arriving while parity is even is odd-numbered, so it counts.
    // The increment lands on the same edge that first samples inc=1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              cnt <= '0;
        else if (rise && odd_seen == PAR_EVEN) cnt <= cnt + WIDTH'(1);
    end

endmodule

// File: tb/tb_odd_pulse_incrementer.sv
module tb_odd_pulse_incrementer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inc = 1'b0;
    logic [W-1:0] cnt;

    odd_pulse_incrementer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .cnt (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic         i;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    // Reference model, used for the long wrap-around run.
    logic         m_prev = 1'b0;
    logic         m_par  = 1'b0;
    logic [W-1:0] m_cnt  = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cnt=%0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, queue the expectation,
    // then pop and compare once the rising edge has updated cnt.
    task automatic drive(input logic r, input logic i, input logic [W-1:0] exp, input string name);
        @(negedge clk);
        rst = r;
        inc = i;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        check(name_q.pop_front(), cnt, exp_q.pop_front());
    endtask

    function automatic logic [W-1:0] model_step(input logic r, input logic i);
        if (!r) begin
            m_prev = 1'b0;
            m_par  = 1'b0;
            m_cnt  = '0;
        end else begin
            if (i && !m_prev) begin
                if (!m_par) m_cnt = m_cnt + 1'b1;
                m_par = ~m_par;
            end
            m_prev = i;
        end
        return m_cnt;
    endfunction

    task automatic drive_model(input logic r, input logic i, input string name);
        logic [W-1:0] e;
        e = model_step(r, i);
        drive(r, i, e, name);
    endtask

    task automatic add(input logic r, input logic i, input logic [W-1:0] e, input string n);
        vec_t v;
        v.r = r; v.i = i; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset held with inc toggling, then release.
        add(0, 1, 0, "rst_hold_inc1");
        add(0, 0, 0, "rst_hold_inc0");
        add(0, 1, 0, "rst_hold_inc1b");
        add(1, 0, 0, "rst_release");
        add(1, 0, 0, "idle_after_rst");
        // Four single-cycle pulses with three idle cycles between.
        for (int p = 0; p < 4; p++) begin
            logic [W-1:0] e;
            e = (p < 2) ? 4'd1 : 4'd2;
            add(1, 1, e, $sformatf("single_p%0d", p + 1));
            for (int g = 0; g < 3; g++) add(1, 0, e, $sformatf("single_gap%0d", p + 1));
        end
        // Long pulse counts once; the following pulse is even.
        add(0, 0, 0, "long_rst");
        for (int k = 0; k < 5; k++) add(1, 1, 1, $sformatf("long_hi%0d", k));
        add(1, 0, 1, "long_lo");
        add(1, 1, 1, "long_next_even");
        add(1, 0, 1, "long_next_lo");
        // Back-to-back 1,0,1,0,1,0.
        add(0, 0, 0, "b2b_rst");
        add(1, 1, 1, "b2b_p1");
        add(1, 0, 1, "b2b_l1");
        add(1, 1, 1, "b2b_p2");
        add(1, 0, 1, "b2b_l2");
        add(1, 1, 2, "b2b_p3");
        add(1, 0, 2, "b2b_l3");
        // inc already high across reset release counts as a pulse.
        add(0, 1, 0, "hi_in_rst");
        add(1, 1, 1, "hi_first_edge");
        add(1, 1, 1, "hi_held");
        add(1, 0, 1, "hi_drop");

        @(negedge clk);
        check("reset_state", cnt, '0);
        foreach (vecs[n]) drive(vecs[n].r, vecs[n].i, vecs[n].exp, vecs[n].name);

        // Wrap-around: 40 pulses -> 20 increments, 15->0 at pulse 31.
        drive_model(0, 0, "wrap_rst");
        for (int p = 1; p <= 40; p++) begin
            drive_model(1, 1, $sformatf("wrap_p%0d", p));
            if (p == 30) check("wrap_at_p30", cnt, 4'd15);
            if (p == 31) check("wrap_at_p31", cnt, 4'd0);
            drive_model(1, 0, $sformatf("wrap_gap%0d", p));
        end
        check("wrap_final", cnt, 4'd4);

        // Mid-stream asynchronous reset between edges clears parity too.
        drive(0, 0, 0, "mid_rst");
        drive(1, 1, 1, "mid_p1");
        drive(1, 0, 1, "mid_l1");
        drive(1, 1, 1, "mid_p2");
        drive(1, 0, 1, "mid_l2");
        drive(1, 1, 2, "mid_p3");
        drive(1, 0, 2, "mid_l3");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_clear", cnt, 4'd0);
        @(posedge clk);
        #1;
        check("mid_held_in_rst", cnt, 4'd0);
        drive(1, 0, 0, "mid_release");
        drive(1, 1, 1, "mid_after_p1");
        drive(1, 0, 1, "mid_after_l1");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
